// File: rtl/ddr3_cmd_sched.sv
// DDR3 command scheduler: round-robin RD/WR arbitration with postponable periodic refresh.
// Latency: selection in ARB is registered, so a command is presented one cycle after arbitration; grants are combinational with the transfer.
// Backpressure: a presented command holds cmd_valid/cmd_type until cmd_ready; no re-arbitration while waiting.
module ddr3_cmd_sched #(
    parameter int TREFI        = 7800,
    parameter int TRFC         = 110,
    parameter int MAX_POSTPONE = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_done,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_type,
    output logic       rd_gnt,
    output logic       wr_gnt,
    output logic       ref_busy,
    output logic [3:0] pending_cnt,
    output logic       ref_overflow
);

    localparam int             ICW   = (TREFI > 1) ? $clog2(TREFI) : 1;
    localparam int             RCW   = $clog2(TRFC + 1);
    localparam logic [ICW-1:0] IMAX  = ICW'(TREFI - 1);
    localparam logic [RCW-1:0] RLOAD = RCW'(TRFC - 1);
    localparam logic [3:0]     PMAX  = 4'(MAX_POSTPONE);

    localparam logic [1:0] C_NOP = 2'b00;
    localparam logic [1:0] C_RD  = 2'b01;
    localparam logic [1:0] C_WR  = 2'b10;
    localparam logic [1:0] C_REF = 2'b11;

    typedef enum logic [1:0] {S_WAIT_INIT, S_ARB, S_ISSUE, S_REF_WAIT} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [ICW-1:0] r_int_cnt;
    logic [RCW-1:0] r_rfc_cnt;
    logic [1:0]     r_cmd;
    logic           r_prio_wr;
    logic [3:0]     r_pend;
    logic           r_ovf;
    logic [1:0]     w_sel;
    logic           w_tick;
    logic           w_xfer;
    logic           w_ref_xfer;

    assign w_tick     = (r_state != S_WAIT_INIT) && (r_int_cnt == IMAX);
    assign w_xfer     = (r_state == S_ISSUE) && cmd_ready;
    assign w_ref_xfer = w_xfer && (r_cmd == C_REF);

    // Arbitration: forced refresh, then round-robin RD/WR, then opportunistic refresh.
    always_comb begin
        w_sel = C_NOP;
        if (r_pend == PMAX)
            w_sel = C_REF;
        else if (rd_req && wr_req)
            w_sel = r_prio_wr ? C_WR : C_RD;
        else if (rd_req)
            w_sel = C_RD;
        else if (wr_req)
            w_sel = C_WR;
        else if (r_pend != 4'd0)
            w_sel = C_REF;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_INIT: if (init_done) w_state_nxt = S_ARB;
            S_ARB:       if (w_sel != C_NOP) w_state_nxt = S_ISSUE;
            S_ISSUE:     if (cmd_ready) w_state_nxt = (r_cmd == C_REF) ? S_REF_WAIT : S_ARB;
            S_REF_WAIT:  if (r_rfc_cnt == '0) w_state_nxt = S_ARB;
            default:     w_state_nxt = S_WAIT_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_WAIT_INIT;
        else       r_state <= w_state_nxt;
    end

    // Refresh interval counter: frozen at zero until init completes, then free-running.
    always_ff @(posedge clk) begin
        if (reset || r_state == S_WAIT_INIT) r_int_cnt <= '0;
        else if (r_int_cnt == IMAX)          r_int_cnt <= '0;
        else                                 r_int_cnt <= r_int_cnt + 1'b1;
    end

    // Latch the selected command and track which requester was served last.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd     <= C_NOP;
            r_prio_wr <= 1'b0;
        end else begin
            if (r_state == S_ARB && w_sel != C_NOP) r_cmd <= w_sel;
            if (w_xfer && r_cmd == C_RD) r_prio_wr <= 1'b1;
            if (w_xfer && r_cmd == C_WR) r_prio_wr <= 1'b0;
        end
    end

    // Refresh recovery timer: loaded on REF transfer, REF_WAIT lasts TRFC cycles.
    always_ff @(posedge clk) begin
        if (reset)                                         r_rfc_cnt <= '0;
        else if (w_ref_xfer)                               r_rfc_cnt <= RLOAD;
        else if (r_state == S_REF_WAIT && r_rfc_cnt != '0) r_rfc_cnt <= r_rfc_cnt - 1'b1;
    end

    // Owed-refresh accounting; a tick and a REF transfer together cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 4'd0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_tick && r_pend == PMAX) r_ovf <= 1'b1;
            if (w_tick && !w_ref_xfer && r_pend != PMAX) r_pend <= r_pend + 4'd1;
            else if (w_ref_xfer && !w_tick)              r_pend <= r_pend - 4'd1;
        end
    end

    // Outputs; command and grants are suppressed in a reset cycle.
    always_comb begin
        cmd_valid    = !reset && (r_state == S_ISSUE);
        cmd_type     = cmd_valid ? r_cmd : C_NOP;
        rd_gnt       = cmd_valid && cmd_ready && (r_cmd == C_RD);
        wr_gnt       = cmd_valid && cmd_ready && (r_cmd == C_WR);
        ref_busy     = (r_state == S_REF_WAIT);
        pending_cnt  = r_pend;
        ref_overflow = r_ovf;
    end

endmodule

// File: tb/tb_ddr3_cmd_sched.sv
// Testbench for ddr3_cmd_sched: directed scenarios plus randomized traffic.
// Outputs are compared every cycle against a cycle-level behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_ddr3_cmd_sched;

    localparam int TREFI = 20;
    localparam int TRFC  = 5;
    localparam int MAXP  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_done = 1'b0;
    logic       rd_req = 1'b0;
    logic       wr_req = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_type;
    logic       rd_gnt;
    logic       wr_gnt;
    logic       ref_busy;
    logic [3:0] pending_cnt;
    logic       ref_overflow;

    int n_chk  = 0;
    int n_fail = 0;

    ddr3_cmd_sched #(.TREFI(TREFI), .TRFC(TRFC), .MAX_POSTPONE(MAXP)) dut (
        .clk(clk), .reset(reset), .init_done(init_done), .rd_req(rd_req), .wr_req(wr_req),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .rd_gnt(rd_gnt),
        .wr_gnt(wr_gnt), .ref_busy(ref_busy), .pending_cnt(pending_cnt), .ref_overflow(ref_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the scheduler as a transaction-level bookkeeping of
    // time-since-init, owed refreshes, the command on offer and recovery time left.
    bit         m_init   = 0;
    int         m_age    = 0;
    int         m_owed   = 0;
    bit         m_ovf    = 0;
    logic [1:0] m_cmd    = 2'd0;   // 0 nothing on offer, 1 RD, 2 WR, 3 REF
    int         m_recov  = 0;
    bit         m_fav_wr = 0;
    bit         m_tick;
    bit         m_xref;
    logic [10:0] m_exp;
    logic [10:0] m_act;

    always @(negedge clk) begin
        if (reset) begin
            chk("gnt_in_reset", 16'({rd_gnt, wr_gnt}), 16'd0);
            m_init = 0; m_age = 0; m_owed = 0; m_ovf = 0;
            m_cmd = 2'd0; m_recov = 0; m_fav_wr = 0;
        end else begin
            m_exp = {m_cmd != 2'd0, m_cmd, (m_cmd == 2'd1) && cmd_ready,
                     (m_cmd == 2'd2) && cmd_ready, m_recov > 0, 4'(m_owed), m_ovf};
            m_act = {cmd_valid, cmd_type, rd_gnt, wr_gnt, ref_busy, pending_cnt, ref_overflow};
            chk("model_outputs", 16'(m_act), 16'(m_exp));
            if (!m_init) begin
                if (init_done) begin m_init = 1; m_age = 0; end
            end else begin
                m_tick = (m_age % TREFI) == TREFI - 1;
                m_age++;
                m_xref = (m_cmd == 2'd3) && cmd_ready;
                if (m_cmd != 2'd0) begin
                    if (cmd_ready) begin
                        if (m_cmd == 2'd1)      m_fav_wr = 1;
                        else if (m_cmd == 2'd2) m_fav_wr = 0;
                        else                    m_recov  = TRFC;
                        m_cmd = 2'd0;
                    end
                end else if (m_recov > 0) begin
                    m_recov--;
                end else begin
                    if (m_owed == MAXP)        m_cmd = 2'd3;
                    else if (rd_req && wr_req) m_cmd = m_fav_wr ? 2'd2 : 2'd1;
                    else if (rd_req)           m_cmd = 2'd1;
                    else if (wr_req)           m_cmd = 2'd2;
                    else if (m_owed > 0)       m_cmd = 2'd3;
                end
                if (m_tick && m_owed == MAXP) m_ovf = 1;
                if (m_tick && !m_xref) begin
                    if (m_owed < MAXP) m_owed++;
                end else if (m_xref && !m_tick) begin
                    m_owed--;
                end
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive_edge(); reset = 1'b1;
        drive_edge();
        drive_edge(); reset = 1'b0;
    endtask

    int q[$];
    int n;
    int cnt;
    logic gr, gw;

    initial begin
        // Reset and a long wait with init_done low.
        repeat (3) drive_edge();
        reset = 1'b0; rd_req = 1'b1; cmd_ready = 1'b1;
        @(negedge clk);
        chk("reset_outputs", 16'({cmd_valid, cmd_type, rd_gnt, wr_gnt, ref_busy, pending_cnt, ref_overflow}), 16'd0);
        repeat (50) @(negedge clk);
        chk("no_init_valid", 16'(cmd_valid), 16'd0);
        chk("no_init_pend", 16'(pending_cnt), 16'd0);

        // init_done rises: ARB next edge, first command one edge later, RR starts at RD.
        drive_edge(); init_done = 1'b1; wr_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("arb_cycle_idle", 16'(cmd_valid), 16'd0);
        n = 0;
        while (q.size() < 4 && n < 40) begin
            @(negedge clk); n++;
            if (n == 1) chk("first_issue", 16'({cmd_valid, cmd_type}), 16'b101);
            if (rd_gnt) q.push_back(1);
            if (wr_gnt) q.push_back(2);
        end
        chk("grant_count", 16'(q.size()), 16'd4);
        for (int i = 0; i < q.size(); i++) chk("rr_order", 16'(q[i]), (i % 2 == 0) ? 16'd1 : 16'd2);

        // Continuous requests postpone refresh until two are owed.
        n = 0;
        do begin @(negedge clk); n++; end while (!(cmd_valid && cmd_type == 2'b11) && n < 120);
        chk("forced_ref_seen", 16'(cmd_valid && cmd_type == 2'b11), 16'd1);
        chk("pend_at_forced_ref", 16'(pending_cnt), 16'd2);
        n = 0;
        while (!ref_busy && n < 10) begin @(negedge clk); n++; end
        chk("pend_in_busy", 16'(pending_cnt), 16'd1);
        cnt = 0;
        while (ref_busy && cnt < 20) begin cnt++; @(negedge clk); end
        chk("busy_len", 16'(cnt), 16'd5);
        n = 0;
        do begin @(negedge clk); n++; end while (!(rd_gnt || wr_gnt) && n < 4);
        chk("rdwr_resume", 16'(rd_gnt || wr_gnt), 16'd1);

        // Opportunistic REF held off by cmd_ready for 7 cycles.
        drive_edge(); rd_req = 1'b0; wr_req = 1'b0; cmd_ready = 1'b0;
        do_reset();
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_valid && n < 40);
        chk("opp_ref_seen", 16'(cmd_valid), 16'd1);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            chk("ref_hold", 16'({cmd_valid, cmd_type}), 16'b111);
        end
        drive_edge(); cmd_ready = 1'b1;
        @(negedge clk);
        cnt = (cmd_valid && cmd_ready && cmd_type == 2'b11) ? 1 : 0;
        drive_edge(); cmd_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready && cmd_type == 2'b11) cnt++;
        end
        chk("ref_xfer_count", 16'(cnt), 16'd1);

        // Stall past three ticks: saturation and sticky overflow.
        drive_edge(); rd_req = 1'b1;
        do_reset();
        repeat (70) @(negedge clk);
        chk("sat_pend", 16'(pending_cnt), 16'd2);
        chk("sat_ovf", 16'(ref_overflow), 16'd1);
        drive_edge(); cmd_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!rd_gnt && n < 5);
        chk("stalled_rd_gnt", 16'(rd_gnt), 16'd1);
        drive_edge(); rd_req = 1'b0;
        repeat (30) @(negedge clk);
        chk("ovf_sticky", 16'(ref_overflow), 16'd1);
        do_reset();
        @(negedge clk);
        chk("ovf_cleared", 16'(ref_overflow), 16'd0);

        // Reset during REF_WAIT.
        n = 0;
        while (!ref_busy && n < 40) begin @(negedge clk); n++; end
        chk("busy_before_rst", 16'(ref_busy), 16'd1);
        drive_edge(); reset = 1'b1; init_done = 1'b0;
        drive_edge(); reset = 1'b0; rd_req = 1'b1;
        @(negedge clk);
        chk("rst_refwait_outs", 16'({cmd_valid, cmd_type, rd_gnt, wr_gnt, ref_busy, pending_cnt, ref_overflow}), 16'd0);
        cnt = 0;
        repeat (10) begin @(negedge clk); if (cmd_valid) cnt++; end
        chk("no_cmd_before_reinit", 16'(cnt), 16'd0);

        // Reset during ISSUE with cmd_ready high in the reset cycle.
        drive_edge(); init_done = 1'b1; cmd_ready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_valid && n < 10);
        chk("issue_before_rst", 16'(cmd_valid), 16'd1);
        drive_edge(); reset = 1'b1; cmd_ready = 1'b1;
        @(negedge clk);
        chk("no_gnt_rst_cycle", 16'(rd_gnt), 16'd0);
        drive_edge(); reset = 1'b0; init_done = 1'b0;
        @(negedge clk);
        chk("rst_issue_outs", 16'({cmd_valid, cmd_type, rd_gnt, wr_gnt, ref_busy, pending_cnt, ref_overflow}), 16'd0);
        repeat (5) @(negedge clk);

        // Randomized traffic; requests are held until granted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); gr = rd_gnt; gw = wr_gnt;
            drive_edge();
            reset     = ($urandom_range(0, 299) == 0);
            init_done = ($urandom_range(0, 9) != 0);
            if (!rd_req || gr) rd_req = ($urandom_range(0, 2) == 0);
            if (!wr_req || gw) wr_req = ($urandom_range(0, 2) == 0);
            cmd_ready = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
